// File: rtl/sha256_stream_interface_pkg.sv
// Shared SHA-256 constants, FSM state encoding and round helper functions
// for the byte-stream hashing block.
package sha256_stream_interface_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ABSORB,
    COMPRESS,
    PAD,
    DONE
  } state_e;

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_compress.sv
// SHA-256 block compression: one round per cycle for 64 cycles, then one
// cycle to add the working variables into the chaining value.
module sha256_compress
  import sha256_stream_interface_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [511:0] block,
  input  logic [255:0] h_in,
  output logic [255:0] h_out,
  output logic         done
);

  logic [31:0]  w_q [16];
  logic [31:0]  v_q [8];
  logic [255:0] base_q;
  logic [6:0]   rnd_q;
  logic         busy_q;
  logic [31:0]  t1, t2, w_new;
  logic [255:0] sum;

  // w_q is a sliding 16-word schedule window; w_q[0] is W[t] for the current round
  always_comb begin
    t1    = v_q[7] + bsig1(v_q[4]) + ch(v_q[4], v_q[5], v_q[6]) + K[rnd_q[5:0]] + w_q[0];
    t2    = bsig0(v_q[0]) + maj(v_q[0], v_q[1], v_q[2]);
    w_new = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
    sum   = '0;
    for (int unsigned i = 0; i < 8; i++)
      sum[255 - 32*i -: 32] = base_q[255 - 32*i -: 32] + v_q[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      done   <= 1'b0;
      rnd_q  <= '0;
      h_out  <= '0;
      base_q <= '0;
      for (int unsigned i = 0; i < 16; i++) w_q[i] <= '0;
      for (int unsigned i = 0; i < 8; i++)  v_q[i] <= '0;
    end else begin
      done <= 1'b0;
      if (start && !busy_q) begin
        busy_q <= 1'b1;
        rnd_q  <= '0;
        base_q <= h_in;
        for (int unsigned i = 0; i < 16; i++) w_q[i] <= block[511 - 32*i -: 32];
        for (int unsigned i = 0; i < 8; i++)  v_q[i] <= h_in[255 - 32*i -: 32];
      end else if (busy_q) begin
        if (rnd_q == 7'd64) begin
          h_out  <= sum;
          done   <= 1'b1;
          busy_q <= 1'b0;
        end else begin
          for (int unsigned i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
          w_q[15] <= w_new;
          v_q[0]  <= t1 + t2;
          v_q[1]  <= v_q[0];
          v_q[2]  <= v_q[1];
          v_q[3]  <= v_q[2];
          v_q[4]  <= v_q[3] + t1;
          v_q[5]  <= v_q[4];
          v_q[6]  <= v_q[5];
          v_q[7]  <= v_q[6];
          rnd_q   <= rnd_q + 7'd1;
        end
      end
    end
  end

endmodule

// File: rtl/sha256_stream_interface.sv
// Byte-stream SHA-256 front end: message buffering, optional chaining-value
// prefix, FIPS 180-4 padding and block sequencing around sha256_compress.
module sha256_stream_interface
  import sha256_stream_interface_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         ready,
  output logic         valid,
  input  logic [7:0]   in_byte,
  input  logic         in_byte_valid,
  output logic         in_byte_ready,
  input  logic         msg_end,
  input  logic [255:0] prev_hash,
  input  logic         use_chain,
  output logic [255:0] hash_out
);

  state_e       state_q, state_d;
  logic [7:0]   buf_q   [64];
  logic [7:0]   pad_blk [64];
  logic [7:0]   len_blk [64];
  logic [31:0]  cnt_q;
  logic [255:0] h_q, hash_q;
  logic         valid_q, ended_q, last_q, need_len_q, go_q;
  logic         accept, fits;
  logic [5:0]   pos;
  logic [63:0]  bit_len;
  logic [511:0] blk_vec;
  logic [255:0] cmp_h;
  logic         cmp_done;

  sha256_compress u_compress (
    .clk   (clk),
    .rst   (rst),
    .start (go_q),
    .block (blk_vec),
    .h_in  (h_q),
    .h_out (cmp_h),
    .done  (cmp_done)
  );

  assign valid    = valid_q;
  assign hash_out = hash_q;

  always_comb begin
    state_d       = state_q;
    ready         = 1'b0;
    in_byte_ready = 1'b0;
    accept        = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        ready = 1'b1;
        if (start) state_d = ABSORB;
      end
      ABSORB: begin
        in_byte_ready = 1'b1;
        accept        = in_byte_valid;
        if (accept && pos == 6'd63) state_d = COMPRESS;
        else if (msg_end)           state_d = PAD;
      end
      PAD: state_d = COMPRESS;
      COMPRESS: begin
        if (cmp_done) begin
          if (last_q)          state_d = DONE;
          else if (need_len_q) state_d = COMPRESS;
          else if (ended_q)    state_d = PAD;
          else                 state_d = ABSORB;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // The buffer fill position is the low six bits of the byte counter.
  always_comb begin
    pos     = cnt_q[5:0];
    bit_len = {29'd0, cnt_q, 3'd0};
    fits    = (pos <= 6'd55);
    blk_vec = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      len_blk[i] = '0;
      if (i < 32'(pos))       pad_blk[i] = buf_q[i];
      else if (i == 32'(pos)) pad_blk[i] = 8'h80;
      else                    pad_blk[i] = '0;
      blk_vec[511 - 8*i -: 8] = buf_q[i];
    end
    for (int unsigned i = 0; i < 8; i++) begin
      len_blk[56 + i] = bit_len[63 - 8*i -: 8];
      if (fits) pad_blk[56 + i] = bit_len[63 - 8*i -: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      h_q        <= '0;
      hash_q     <= '0;
      valid_q    <= 1'b0;
      ended_q    <= 1'b0;
      last_q     <= 1'b0;
      need_len_q <= 1'b0;
      go_q       <= 1'b0;
      for (int unsigned i = 0; i < 64; i++) buf_q[i] <= '0;
    end else begin
      go_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            valid_q    <= 1'b0;
            h_q        <= IV;
            ended_q    <= 1'b0;
            last_q     <= 1'b0;
            need_len_q <= 1'b0;
            cnt_q      <= use_chain ? 32'd32 : 32'd0;
            for (int unsigned i = 0; i < 64; i++) buf_q[i] <= '0;
            if (use_chain)
              for (int unsigned i = 0; i < 32; i++) buf_q[i] <= prev_hash[255 - 8*i -: 8];
          end
        end
        ABSORB: begin
          if (accept) begin
            buf_q[pos] <= in_byte;
            cnt_q      <= cnt_q + 32'd1;
            if (pos == 6'd63) go_q <= 1'b1;
          end
          if (msg_end) ended_q <= 1'b1;
        end
        PAD: begin
          for (int unsigned i = 0; i < 64; i++) buf_q[i] <= pad_blk[i];
          last_q     <= fits;
          need_len_q <= !fits;
          go_q       <= 1'b1;
        end
        COMPRESS: begin
          if (cmp_done) begin
            h_q <= cmp_h;
            if (last_q) begin
              hash_q  <= cmp_h;
              valid_q <= 1'b1;
            end else if (need_len_q) begin
              for (int unsigned i = 0; i < 64; i++) buf_q[i] <= len_blk[i];
              need_len_q <= 1'b0;
              last_q     <= 1'b1;
              go_q       <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_stream_interface.sv
// Directed self-checking bench for sha256_stream_interface using known
// FIPS 180-4 digests.
module tb_sha256_stream_interface;

  logic         clk = 1'b0;
  logic         rst, start, in_byte_valid, msg_end, use_chain;
  logic [7:0]   in_byte;
  logic [255:0] prev_hash;
  logic         ready, valid, in_byte_ready;
  logic [255:0] hash_out;

  int total = 0;
  int bad   = 0;

  logic [7:0] msg [128];
  int         msg_len;
  int         max_stall;
  logic       valid_after_start;

  localparam logic [255:0] D_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_56    = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] D_CHAIN = 256'h66687aadf862bd776c8fc18b8e9f8e20089714856ee233b3902a591d0d5f2925;
  localparam logic [255:0] D_112   = 256'hcf5b16a778af8380036ce59e7b0492370b249b11e8f07a51afac45037afee9d1;

  always #5 clk = ~clk;

  sha256_stream_interface dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .ready         (ready),
    .valid         (valid),
    .in_byte       (in_byte),
    .in_byte_valid (in_byte_valid),
    .in_byte_ready (in_byte_ready),
    .msg_end       (msg_end),
    .prev_hash     (prev_hash),
    .use_chain     (use_chain),
    .hash_out      (hash_out)
  );

  task automatic load(input string s);
    msg_len = s.len();
    for (int i = 0; i < msg_len; i++) msg[i] = s[i];
  endtask

  // Inputs change on the falling edge; in_byte_ready is stable there.
  task automatic send_msg(input logic chain, input logic [255:0] ph, input bit bp);
    int i, guard, stall;
    bit acc;
    @(negedge clk);
    use_chain = chain;
    prev_hash = ph;
    start     = 1'b1;
    @(negedge clk);
    start             = 1'b0;
    use_chain         = 1'b0;
    prev_hash         = '0;
    valid_after_start = valid;
    i = 0; guard = 0; stall = 0; max_stall = 0;
    if (msg_len == 0) begin
      msg_end = 1'b1;
      @(negedge clk);
      msg_end = 1'b0;
    end
    while (i < msg_len && guard < 20000) begin
      in_byte       = msg[i];
      in_byte_valid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bp) start = 1'($urandom_range(0, 1));
      acc     = in_byte_valid && in_byte_ready;
      msg_end = (i == msg_len - 1) && acc;
      if (!in_byte_ready) stall++;
      else begin
        if (stall > max_stall) max_stall = stall;
        stall = 0;
      end
      @(negedge clk);
      if (acc) i++;
      guard++;
    end
    in_byte_valid = 1'b0;
    msg_end       = 1'b0;
    start         = 1'b0;
    if (i < msg_len) begin
      total++; bad++;
      $display("FAIL send_timeout sent=%0d want=%0d", i, msg_len);
    end
  endtask

  task automatic check_digest(input string name, input logic [255:0] exp);
    int n = 0;
    while (!valid && n < 2000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (valid !== 1'b1) begin
      bad++;
      $display("FAIL %s_valid got=%b want=1", name, valid);
    end
    total++;
    if (hash_out !== exp) begin
      bad++;
      $display("FAIL %s_digest got=%h want=%h", name, hash_out, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    total++; if (ready !== 1'b1)         begin bad++; $display("FAIL rst_ready got=%b want=1", ready); end
    total++; if (valid !== 1'b0)         begin bad++; $display("FAIL rst_valid got=%b want=0", valid); end
    total++; if (in_byte_ready !== 1'b0) begin bad++; $display("FAIL rst_in_byte_ready got=%b want=0", in_byte_ready); end
    total++; if (hash_out !== '0)        begin bad++; $display("FAIL rst_hash got=%h want=0", hash_out); end
  endtask

  task automatic test_empty();
    load("");
    send_msg(1'b0, '0, 1'b0);
    check_digest("empty", D_EMPTY);
    repeat (10) @(negedge clk);
    total++; if (valid !== 1'b1)     begin bad++; $display("FAIL hold_valid got=%b want=1", valid); end
    total++; if (hash_out !== D_EMPTY) begin bad++; $display("FAIL hold_hash got=%h want=%h", hash_out, D_EMPTY); end
  endtask

  task automatic test_abc();
    load("abc");
    send_msg(1'b0, '0, 1'b0);
    total++; if (valid_after_start !== 1'b0) begin bad++; $display("FAIL start_clears_valid got=%b want=0", valid_after_start); end
    check_digest("abc", D_ABC);
  endtask

  task automatic test_pad_block();
    load("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    send_msg(1'b0, '0, 1'b0);
    check_digest("pad56", D_56);
  endtask

  task automatic test_chain();
    load("");
    send_msg(1'b1, '0, 1'b0);
    check_digest("chain0", D_CHAIN);
  endtask

  task automatic test_backpressure();
    load("abc");
    send_msg(1'b0, '0, 1'b1);
    check_digest("bp_abc", D_ABC);
  endtask

  task automatic test_long();
    load({"abcdefghbcdefghicdefghijdefghijkefghijklfghijklmghijklmn",
          "hijklmnoijklmnopjklmnopqklmnopqrlmnopqrsmnopqrstnopqrstu"});
    send_msg(1'b0, '0, 1'b0);
    total++;
    if (max_stall < 65) begin
      bad++;
      $display("FAIL compress_stall got=%0d want>=65", max_stall);
    end
    check_digest("long112", D_112);
  endtask

  task automatic test_rst_mid();
    int seen;
    load("abc");
    send_msg(1'b0, '0, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL mid_rst_ready got=%b want=1", ready); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got=%b want=0", valid); end
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (valid) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL mid_rst_no_digest got=%0d want=0", seen); end
    send_msg(1'b0, '0, 1'b0);
    check_digest("after_rst_abc", D_ABC);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_byte_valid = 1'b0; msg_end = 1'b0;
    use_chain = 1'b0; in_byte = '0; prev_hash = '0;
    valid_after_start = 1'b1;
    test_reset();
    test_empty();
    test_abc();
    test_pad_block();
    test_chain();
    test_backpressure();
    test_long();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
